// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer driving PC enable and per-stage en/flush (load-use, redirect, mem wait, halt).
// Define HAZARD_PERF_EN to add saturating stall_cnt/flush_cnt outputs.
module hazard_ctrl #(
    parameter int REGW  = 5,
    parameter int SAT_W = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            mem_dren,
    input  logic            mem_dwen,
    input  logic            idex_memread,
    input  logic [REGW-1:0] idex_rd,
    input  logic [REGW-1:0] ifid_rs,
    input  logic [REGW-1:0] ifid_rt,
    input  logic            ifid_uses_rt,
    input  logic            jump_id,
    input  logic            branch_ex,
    input  logic            halt_wb,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            ifid_flush,
    output logic            idex_en,
    output logic            idex_flush,
    output logic            exmem_en,
    output logic            exmem_flush,
    output logic            memwb_en,
    output logic            memwb_flush,
    output logic            halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [SAT_W-1:0] stall_cnt,
    output logic [SAT_W-1:0] flush_cnt
`endif
);
    typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

    state_t state, nxt;
    logic   dwait, lu, frz, go;

    // a pending data access keeps the pipe frozen until dhit, even if the request drops
    assign dwait = ((state == DWAIT) | mem_dren | mem_dwen) & ~dhit;
    assign lu    = idex_memread & (idex_rd != '0) &
                   ((idex_rd == ifid_rs) | (ifid_uses_rt & (idex_rd == ifid_rt)));
    assign frz   = (state == HALTED) | halt_wb | dwait;
    assign go    = ~RST & ~frz;

    always_comb begin
        pc_en       = go & (branch_ex | (~lu & (jump_id | ihit)));
        ifid_en     = go & (branch_ex | ~lu);
        ifid_flush  = RST | (go & (branch_ex | (~lu & (jump_id | ~ihit))));
        idex_en     = go;
        idex_flush  = RST | (go & (branch_ex | lu));
        exmem_en    = go;
        exmem_flush = RST;
        memwb_en    = go;
        memwb_flush = RST;
        nxt         = (state == HALTED || halt_wb) ? HALTED : dwait ? DWAIT : RUN;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            state  <= nxt;
            halted <= (nxt == HALTED);
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state != HALTED) begin
            if (~pc_en && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush && ~&flush_cnt) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif
endmodule
